ctrl_packer: RTL and testbench



---
 rtl/ctrl_packer_if.sv | 30 +++
 rtl/ctrl_packer.sv | 145 ++++++++++++++
 tb/tb_ctrl_packer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_packer_if.sv
// Handshake bundle between the control unit, ctrl_packer and the dispatch logic.
// The slave modport is the packer's view; master is the surrounding pipeline.
interface ctrl_packer_if #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      ctrl_flags;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_opcode;
    logic             out_wb;
    logic             out_err;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] err_count;

    modport slave (
        input  flush, in_valid, ctrl_flags, out_ready,
        output in_ready, out_valid, out_opcode, out_wb, out_err, occupancy, err_count
    );

    modport master (
        output flush, in_valid, ctrl_flags, out_ready,
        input  in_ready, out_valid, out_opcode, out_wb, out_err, occupancy, err_count
    );
endinterface

// File: rtl/ctrl_packer.sv
// Packs a one-hot 16-flag control bundle into a 4-bit opcode entry, checks legality,
// and buffers entries in a small valid/ready FIFO with a saturating illegal-bundle counter.
module ctrl_packer #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    ctrl_packer_if.slave  bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
    localparam int unsigned FLG_W = 16;
    localparam int unsigned WB_BIT = 14;

    typedef struct packed {
        logic [3:0] opcode;
        logic       wb;
        logic       err;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic [CNT_W-1:0]   err_cnt;

    logic [FLG_W-1:0]   ops;
    logic               multi;
    logic               wb;
    logic               need_wb;
    logic [3:0]         opc;
    logic               illegal;
    entry_t             enc;

    logic               full;
    logic               empty;
    logic               in_ready_c;
    logic               push;
    logic               pop;

    // Encoder: op flags with the wb bit masked out, then table lookup.
    always_comb begin
        ops     = bus.ctrl_flags;
        ops[WB_BIT] = 1'b0;
        wb      = bus.ctrl_flags[WB_BIT];
        multi   = (ops & (ops - FLG_W'(1))) != '0;
        opc     = 4'd0;
        need_wb = 1'b0;
        case (ops)
            16'h0001: begin opc = 4'd1;  need_wb = 1'b1; end // add
            16'h0002: begin opc = 4'd2;  need_wb = 1'b1; end // sub
            16'h0004: begin opc = 4'd3;  need_wb = 1'b1; end // mul
            16'h0008: begin opc = 4'd4;  need_wb = 1'b1; end // ld
            16'h0010: begin opc = 4'd5;  need_wb = 1'b0; end // st
            16'h0020: begin opc = 4'd6;  need_wb = 1'b0; end // cmp
            16'h0040: begin opc = 4'd7;  need_wb = 1'b1; end // mov
            16'h0080: begin opc = 4'd8;  need_wb = 1'b1; end // or
            16'h0100: begin opc = 4'd9;  need_wb = 1'b1; end // and
            16'h0200: begin opc = 4'd10; need_wb = 1'b1; end // not
            16'h0400: begin opc = 4'd11; need_wb = 1'b1; end // lsl
            16'h0800: begin opc = 4'd13; need_wb = 1'b1; end // lsr
            16'h1000: begin opc = 4'd14; need_wb = 1'b0; end // beq
            16'h2000: begin opc = 4'd15; need_wb = 1'b0; end // bgt
            16'h8000: begin opc = 4'd12; need_wb = 1'b0; end // ubranch
            default:  begin opc = 4'd0;  need_wb = 1'b0; end // nop or multi-hot
        endcase

        if (multi) begin
            illegal = 1'b1;
        end else begin
            illegal = (wb != need_wb);
        end

        if (illegal) begin
            enc = '{opcode: 4'd0, wb: 1'b0, err: 1'b1};
        end else begin
            enc = '{opcode: opc, wb: wb, err: 1'b0};
        end
    end

    // Handshake: no combinational path from out_ready into in_ready.
    always_comb begin
        full       = (occ == OCC_W'(DEPTH));
        empty      = (occ == '0);
        in_ready_c = !full && !bus.flush;
        push       = bus.in_valid && in_ready_c;
        pop        = !empty && bus.out_ready;
    end

    // Pointers, occupancy and the sticky illegal-bundle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            err_cnt <= '0;
        end else begin
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    occ <= occ + OCC_W'(1);
                end else if (pop && !push) begin
                    occ <= occ - OCC_W'(1);
                end
            end
            if (push && enc.err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc;
        end
    end

    entry_t head;
    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem[rd_ptr];
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = !empty;
    assign bus.out_opcode = head.opcode;
    assign bus.out_wb     = head.wb;
    assign bus.out_err    = head.err;
    assign bus.occupancy  = occ;
    assign bus.err_count  = err_cnt;

endmodule

// File: tb/tb_ctrl_packer.sv
// Scoreboard bench for ctrl_packer: directed test-plan scenarios plus random traffic,
// checked against a flag-table reference model and a modelled FIFO occupancy.
module tb_ctrl_packer;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned ERR_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic reset;

    ctrl_packer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    ctrl_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference tables indexed by flag bit: opcode and whether wb is mandatory.
    int unsigned opc_of_bit [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 14, 15, 0, 12};
    bit          wb_of_bit  [16] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};

    logic [5:0] exp_q [$];
    int         m_occ = 0;
    int         m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {opcode, wb, err}.
    function automatic logic [5:0] model_encode(input logic [15:0] f);
        logic [15:0] ops;
        bit          w;
        int          n;
        int          idx;
        ops     = f;
        ops[14] = 1'b0;
        w       = f[14];
        n       = $countones(ops);
        idx     = 0;
        for (int b = 0; b < 16; b++) if (ops[b]) idx = b;
        if (n == 0) return w ? 6'b0000_0_1 : 6'b0000_0_0;
        if (n > 1) return 6'b0000_0_1;
        if (w != wb_of_bit[idx]) return 6'b0000_0_1;
        return {4'(opc_of_bit[idx]), w, 1'b0};
    endfunction

    // Model of the accepting edge: push expectations, track occupancy and error count.
    always @(posedge clk) begin
        bit         accept;
        bit         popm;
        logic [5:0] e;
        accept = bus.in_valid && !bus.flush && (m_occ < DEPTH);
        popm   = (m_occ != 0) && bus.out_ready;
        if (reset) begin
            m_occ = 0;
            m_err = 0;
            exp_q.delete();
        end else if (bus.flush) begin
            m_occ = 0;
            exp_q.delete();
        end else begin
            if (accept) begin
                e = model_encode(bus.ctrl_flags);
                exp_q.push_back(e);
                if (e[0] && m_err < ERR_MAX) m_err++;
            end
            m_occ = m_occ + int'(accept) - int'(popm);
        end
    end

    // Monitor: compare status every cycle, pop and compare the head on each handshake.
    always @(negedge clk) begin
        logic [5:0] e;
        chk("occupancy", 32'(bus.occupancy), 32'(m_occ));
        chk("in_ready", 32'(bus.in_ready), 32'((m_occ < DEPTH) && !bus.flush));
        chk("err_count", 32'(bus.err_count), 32'(m_err));
        chk("out_valid", 32'(bus.out_valid), 32'(m_occ != 0));
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'(bus.out_opcode), 32'hFFFF_FFFF);
            end else begin
                e = exp_q[0];
                chk("out_opcode", 32'(bus.out_opcode), 32'(e[5:2]));
                chk("out_wb", 32'(bus.out_wb), 32'(e[1]));
                chk("out_err", 32'(bus.out_err), 32'(e[0]));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end else begin
            chk("empty_mask", 32'({bus.out_opcode, bus.out_wb, bus.out_err}), 32'd0);
        end
    end

    task automatic step(input logic v, input logic [15:0] f, input logic r, input logic fl);
        bus.in_valid   = v;
        bus.ctrl_flags = f;
        bus.out_ready  = r;
        bus.flush      = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] f;
        int          idx;
        reset = 1'b1;
        step(0, 16'h0000, 0, 0);
        step(0, 16'h0000, 0, 0);
        reset = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);

        // Single legal op: visible one edge after acceptance, gone one edge later.
        step(1, 16'h4001, 1, 0);
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_opcode", 32'(bus.out_opcode), 32'd1);
        chk("add_wb", 32'(bus.out_wb), 32'd1);
        step(0, 16'h0000, 1, 0);
        chk("add_drained", 32'(bus.out_valid), 32'd0);

        // Backpressure: fill, third push refused, then drain in order.
        step(1, 16'h0010, 0, 0);
        step(1, 16'h1000, 0, 0);
        chk("bp_occupancy", 32'(bus.occupancy), 32'd2);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        step(1, 16'h4001, 0, 0);
        chk("bp_third_refused", 32'(bus.occupancy), 32'd2);
        chk("bp_head_st", 32'(bus.out_opcode), 32'd5);
        repeat (3) step(0, 16'h0000, 1, 0);

        // Illegal bundles, NOP and wb-only.
        step(1, 16'h4003, 1, 0);
        step(1, 16'h0001, 1, 0);
        chk("illegal_count", 32'(bus.err_count), 32'd2);
        step(1, 16'h0000, 1, 0);
        chk("nop_count", 32'(bus.err_count), 32'd2);
        step(1, 16'h4000, 1, 0);
        chk("wbonly_count", 32'(bus.err_count), 32'd3);
        step(0, 16'h0000, 1, 0);

        // Flush drops held entries and the bundle presented with it.
        step(1, 16'h4002, 0, 0);
        step(1, 16'h4100, 0, 0);
        step(1, 16'h4008, 0, 1);
        chk("flush_occupancy", 32'(bus.occupancy), 32'd0);
        chk("flush_keeps_err", 32'(bus.err_count), 32'd3);
        step(0, 16'h0000, 1, 0);
        chk("flush_no_ld", 32'(bus.out_valid), 32'd0);

        // Reset mid-stream overrides flush and handshake.
        step(1, 16'h4001, 0, 0);
        step(1, 16'h0003, 0, 0);
        reset = 1'b1;
        step(1, 16'h4004, 1, 1);
        reset = 1'b0;
        step(0, 16'h0000, 0, 0);
        chk("midrst_occupancy", 32'(bus.occupancy), 32'd0);
        chk("midrst_err_count", 32'(bus.err_count), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);

        // Streaming across pointer wrap, then counter saturation.
        for (int i = 0; i < 300; i++) step(1, (i % 2) ? 16'h8000 : 16'h4004, 1, 0);
        for (int i = 0; i < 300; i++) step(1, 16'h0003, 1, 0);
        chk("err_saturated", 32'(bus.err_count), 32'(ERR_MAX));

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: f = 16'($urandom);
                1: f = 16'h0000;
                default: begin
                    idx = $urandom_range(0, 14);
                    if (idx == 14) idx = 15;
                    f = 16'(1) << idx;
                    f[14] = ($urandom_range(0, 3) != 0) ? 1'(wb_of_bit[idx]) : !wb_of_bit[idx];
                end
            endcase
            step($urandom_range(0, 3) != 0, f, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        repeat (4) step(0, 16'h0000, 1, 0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
